// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : uart_pkg                                             |
// | Description : Shared UART frame definitions (state encodings,      |
// |               data width, parity seed) for transmitter/receiver.   |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
package uart_pkg;

  // Receiver/transmitter frame phases
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int   FRAME_DATA_BITS = 8;
  // Seed for the running parity accumulator (even parity)
  localparam logic PARITY_EVEN     = 1'b0;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : uart_rx_sync                                         |
// | Description : Two-flop synchronizer for the serial line plus a     |
// |               delayed copy used for falling-edge detection.        |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resynchronise rx; all flops reset to 1 so an idle line never looks like an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s_o      = sync_q;
  assign fall_edge_o = prev_q & ~sync_q;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : uart_rx                                              |
// | Description : UART receiver, 8 data bits LSB first, even parity,   |
// |               one stop bit. Centre-samples each bit and reports    |
// |               every byte with a one-cycle valid pulse.             |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_i,
  output logic [FRAME_DATA_BITS-1:0] dataout_o,
  output logic                       valid_o,
  output logic                       parity_err_o,
  output logic                       frame_err_o,
  output logic                       busy_o
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [2:0]       BIT_IDX_LAST  = 3'(FRAME_DATA_BITS - 1);

  logic rx_s;
  logic fall_edge;

  uart_state_e                state_q,      state_d;
  logic [CNT_W-1:0]           cnt_q,        cnt_d;
  logic [2:0]                 bit_idx_q,    bit_idx_d;
  logic [FRAME_DATA_BITS-1:0] shift_q,      shift_d;
  logic                       par_q,        par_d;
  logic                       perr_q,       perr_d;
  logic [FRAME_DATA_BITS-1:0] dataout_q,    dataout_d;
  logic                       valid_q,      valid_d;
  logic                       parity_err_q, parity_err_d;
  logic                       frame_err_q,  frame_err_d;
  logic                       busy_q,       busy_d;

  uart_rx_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .rx_s_o      (rx_s),
    .fall_edge_o (fall_edge)
  );

  // State, counters, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_q        <= PARITY_EVEN;
      perr_q       <= 1'b0;
      dataout_q    <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      perr_q       <= perr_d;
      dataout_q    <= dataout_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  // Frame FSM: next state, bit-timing counter and sampled-data updates
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    perr_d       = perr_q;
    dataout_d    = dataout_q;
    valid_d      = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    busy_d       = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Only a 1->0 transition starts a frame; a line parked low is ignored
        if (fall_edge) begin
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            // Line back high at start centre: a glitch, not a frame
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            bit_idx_d = '0;
            par_d     = PARITY_EVEN;
            state_d   = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          par_d              = par_q ^ rx_s;
          if (bit_idx_q == BIT_IDX_LAST) begin
            state_d = ST_PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PARITY: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d   = '0;
          perr_d  = rx_s ^ par_q;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          // Deliver the byte even on a bad stop bit; leave at stop centre
          // so a following start edge is caught without an idle bit
          cnt_d        = '0;
          dataout_d    = shift_q;
          valid_d      = 1'b1;
          parity_err_d = perr_q;
          frame_err_d  = ~rx_s;
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dataout_o    = dataout_q;
  assign valid_o      = valid_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = busy_q;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_uart_rx                                           |
// | Description : Directed self-checking bench for uart_rx.            |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] dataout;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int tests;
  int fails;

  // Records of every valid pulse seen
  int         cyc;
  logic [7:0] q_data[$];
  logic       q_perr[$];
  logic       q_ferr[$];
  int         q_cyc[$];
  logic       valid_prev;
  int         long_valid;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx),
    .dataout_o    (dataout),
    .valid_o      (valid),
    .parity_err_o (parity_err),
    .frame_err_o  (frame_err),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Capture each valid pulse, away from the active edge
  always @(negedge clk) begin
    valid_prev <= valid;
    if (valid) begin
      q_data.push_back(dataout);
      q_perr.push_back(parity_err);
      q_ferr.push_back(frame_err);
      q_cyc.push_back(cyc);
      if (valid_prev) long_valid <= long_valid + 1;
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  // Compare the most recent captured frame against expectations
  task automatic check_frame(input string name, input int n0, input logic [7:0] d,
                             input logic pe, input logic fe);
    tests++;
    if (q_data.size() !== n0 + 1) begin
      fails++;
      $display("FAIL %s valid count: got %0d required %0d", name, q_data.size() - n0, 1);
    end
    if (q_data.size() > n0) begin
      tests++;
      if (q_data[n0] !== d) begin
        fails++;
        $display("FAIL %s data: got %h required %h", name, q_data[n0], d);
      end
      tests++;
      if (q_perr[n0] !== pe) begin
        fails++;
        $display("FAIL %s parity_err: got %b required %b", name, q_perr[n0], pe);
      end
      tests++;
      if (q_ferr[n0] !== fe) begin
        fails++;
        $display("FAIL %s frame_err: got %b required %b", name, q_ferr[n0], fe);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({dataout, valid, parity_err, frame_err, busy} !== 12'h000) begin
      fails++;
      $display("FAIL reset outputs: got %h/%b%b%b%b required 00/0000",
               dataout, valid, parity_err, frame_err, busy);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if ({dataout, valid, parity_err, frame_err, busy} !== 12'h000) begin
      fails++;
      $display("FAIL post-reset idle: got %h/%b%b%b%b required 00/0000",
               dataout, valid, parity_err, frame_err, busy);
    end
  endtask

  task automatic test_good_byte();
    int n0;
    n0 = q_data.size();
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_bits(1);
    check_frame("good_A5", n0, 8'hA5, 1'b0, 1'b0);
  endtask

  task automatic test_parity_err();
    int n0;
    n0 = q_data.size();
    send_frame(8'h01, 1'b0, 1'b1);
    idle_bits(1);
    check_frame("parity_01", n0, 8'h01, 1'b1, 1'b0);
  endtask

  task automatic test_frame_err();
    int n0;
    n0 = q_data.size();
    send_frame(8'h3C, 1'b0, 1'b0);
    check_frame("frame_3C", n0, 8'h3C, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    tests++;
    if (q_data.size() !== n0 + 1) begin
      fails++;
      $display("FAIL stuck_low valids: got %0d required %0d", q_data.size() - n0, 1);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL stuck_low busy: got %b required 0", busy);
    end
    idle_bits(2);
    n0 = q_data.size();
    send_frame(8'h55, 1'b0, 1'b1);
    idle_bits(1);
    check_frame("recover_55", n0, 8'h55, 1'b0, 1'b0);
  endtask

  task automatic test_false_start();
    int  n0;
    logic saw_busy;
    n0 = q_data.size();
    saw_busy = 1'b0;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    tests++;
    if (saw_busy !== 1'b1) begin
      fails++;
      $display("FAIL false_start busy rise: got %b required 1", saw_busy);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL false_start busy fall: got %b required 0", busy);
    end
    tests++;
    if (q_data.size() !== n0) begin
      fails++;
      $display("FAIL false_start valids: got %0d required 0", q_data.size() - n0);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = q_data.size();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle_bits(1);
    tests++;
    if (q_data.size() !== n0 + 2) begin
      fails++;
      $display("FAIL b2b valid count: got %0d required 2", q_data.size() - n0);
    end else begin
      tests++;
      if (q_cyc[n0 + 1] - q_cyc[n0] !== 11 * CPB) begin
        fails++;
        $display("FAIL b2b spacing: got %0d required %0d", q_cyc[n0 + 1] - q_cyc[n0], 11 * CPB);
      end
      tests++;
      if ({q_data[n0], q_data[n0 + 1]} !== 16'h00FF) begin
        fails++;
        $display("FAIL b2b data: got %h %h required 00 ff", q_data[n0], q_data[n0 + 1]);
      end
      tests++;
      if ({q_perr[n0], q_ferr[n0], q_perr[n0 + 1], q_ferr[n0 + 1]} !== 4'b0000) begin
        fails++;
        $display("FAIL b2b errors: got %b%b%b%b required 0000",
                 q_perr[n0], q_ferr[n0], q_perr[n0 + 1], q_ferr[n0 + 1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    n0 = q_data.size();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({dataout, valid, parity_err, frame_err, busy} !== 12'h000) begin
      fails++;
      $display("FAIL mid_reset outputs: got %h/%b%b%b%b required 00/0000",
               dataout, valid, parity_err, frame_err, busy);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_bits(12);
    tests++;
    if (q_data.size() !== n0) begin
      fails++;
      $display("FAIL mid_reset valids: got %0d required 0", q_data.size() - n0);
    end
    n0 = q_data.size();
    send_frame(8'h12, 1'b0, 1'b1);
    idle_bits(1);
    check_frame("after_reset_12", n0, 8'h12, 1'b0, 1'b0);
  endtask

  task automatic test_valid_width();
    tests++;
    if (long_valid !== 0) begin
      fails++;
      $display("FAIL valid width: got %0d multi-cycle pulses required 0", long_valid);
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    cyc        = 0;
    long_valid = 0;
    valid_prev = 1'b0;
    rst        = 1'b1;
    rx         = 1'b1;
    @(negedge clk);
    test_reset();
    test_good_byte();
    test_parity_err();
    test_frame_err();
    test_false_start();
    test_back_to_back();
    test_reset_mid_frame();
    test_valid_width();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire
